// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared constants for the multi-cycle RISC-V control unit
package uc_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_R  = 4'b0000;
  localparam logic [3:0] ALU_I  = 4'b0001;
  localparam logic [3:0] ALU_S  = 4'b0010;
  localparam logic [3:0] ALU_SB = 4'b0011;
  localparam logic [3:0] ALU_U  = 4'b0100;
  localparam logic [3:0] ALU_UJ = 4'b0101;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd7;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } instr_class_e;

endpackage

// File: rtl/uc_decode.sv
// rtl/uc_decode.sv - combinational opcode/funct3 classifier
module uc_decode
  import uc_pkg::*;
(
  input  logic [6:0]   op_i,
  input  logic [2:0]   f3_i,
  output logic         supported_o,
  output instr_class_e cls_o,
  output logic [3:0]   alu_cmd_o,
  output logic         alu_src_o,
  output logic         br_valid_o,
  output logic         br_on_zero_o
);

  always_comb begin
    supported_o = 1'b1;
    cls_o       = CLS_NONE;
    alu_cmd_o   = ALU_R;
    alu_src_o   = 1'b0;
    case (op_i)
      OPC_OP:     begin cls_o = CLS_R; end
      OPC_OP_IMM: begin cls_o = CLS_I;      alu_cmd_o = ALU_I;  alu_src_o = 1'b1; end
      OPC_LOAD:   begin cls_o = CLS_LOAD;   alu_cmd_o = ALU_I;  alu_src_o = 1'b1; end
      OPC_STORE:  begin cls_o = CLS_STORE;  alu_cmd_o = ALU_S;  alu_src_o = 1'b1; end
      OPC_BRANCH: begin cls_o = CLS_BRANCH; alu_cmd_o = ALU_SB; end
      default:    begin supported_o = 1'b0; end
    endcase
  end

  // Branches other than BEQ/BNE are recognised but never taken.
  assign br_valid_o   = (f3_i == F3_BEQ) || (f3_i == F3_BNE);
  assign br_on_zero_o = (f3_i == F3_BEQ);

endmodule

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multi-cycle control unit: state register, IR field latches, output decode
module uc_multiciclo
  import uc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [3:0] alu_flags,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic       rf_we,
  output logic       rf_src,
  output logic       d_mem_we,
  output logic       alu_src,
  output logic [3:0] alu_cmd,
  output logic       halted,
  output logic [2:0] state_dbg
);

  logic [2:0]   state_q, state_d;
  logic [6:0]   op_q, op_d;
  logic [2:0]   f3_q, f3_d;
  logic [6:0]   dec_op;
  logic [2:0]   dec_f3;
  logic         supported;
  instr_class_e cls;
  logic [3:0]   dec_cmd;
  logic         dec_src;
  logic         br_valid;
  logic         br_on_zero;
  logic         br_taken;
  logic         unused_flags;

  assign unused_flags = ^alu_flags[3:1];

  // In DECODE the live IR fields are classified so the branch to HALT needs no extra cycle.
  assign dec_op = (state_q == ST_DECODE) ? opcode : op_q;
  assign dec_f3 = (state_q == ST_DECODE) ? funct3 : f3_q;

  uc_decode u_decode (
    .op_i         (dec_op),
    .f3_i         (dec_f3),
    .supported_o  (supported),
    .cls_o        (cls),
    .alu_cmd_o    (dec_cmd),
    .alu_src_o    (dec_src),
    .br_valid_o   (br_valid),
    .br_on_zero_o (br_on_zero)
  );

  assign br_taken = br_valid && (alu_flags[0] == br_on_zero);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    f3_d    = f3_q;
    if (rst) begin
      state_d = ST_FETCH;
      op_d    = '0;
      f3_d    = '0;
    end else begin
      case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          op_d    = opcode;
          f3_d    = funct3;
          state_d = supported ? ST_EXEC : ST_HALT;
        end
        ST_EXEC: begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_BRANCH:          state_d = ST_FETCH;
            default:             state_d = ST_WB;
          endcase
        end
        ST_MEM:  state_d = (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:   state_d = ST_FETCH;
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    op_q    <= op_d;
    f3_q    <= f3_d;
  end

  always_comb begin
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    rf_we     = 1'b0;
    rf_src    = 1'b0;
    d_mem_we  = 1'b0;
    alu_src   = 1'b0;
    alu_cmd   = 4'b0000;
    halted    = 1'b0;
    state_dbg = 3'd0;
    if (!rst) begin
      state_dbg = state_q;
      // ALU controls are held through EXEC..WB so address and result stay stable.
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        alu_cmd = dec_cmd;
        alu_src = dec_src;
      end
      case (state_q)
        ST_FETCH: ir_we = 1'b1;
        ST_EXEC: begin
          if (cls == CLS_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = br_taken;
          end
        end
        ST_MEM: begin
          if (cls == CLS_STORE) begin
            d_mem_we = 1'b1;
            pc_we    = 1'b1;
          end else begin
            rf_src = 1'b1;
          end
        end
        ST_WB: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          rf_src = (cls == CLS_LOAD);
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - scoreboard bench for the multi-cycle control unit
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [3:0] alu_flags = '0;
  logic       ir_we, pc_we, pc_src, rf_we, rf_src, d_mem_we, alu_src, halted;
  logic [3:0] alu_cmd;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  uc_multiciclo dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .alu_flags (alu_flags),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .rf_we     (rf_we),
    .rf_src    (rf_src),
    .d_mem_we  (d_mem_we),
    .alu_src   (alu_src),
    .alu_cmd   (alu_cmd),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  typedef struct {
    string       nm;
    logic [14:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   stim_done = 1'b0;

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] SD   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b0110111;

  // Packed order: ir pcwe pcsrc rfwe rfsrc dwe asrc cmd[4] halt st[3]
  function automatic logic [14:0] mk(input logic [2:0] st, input logic ir, input logic pw,
                                     input logic ps, input logic rw, input logic rs,
                                     input logic dw, input logic as, input logic [3:0] ac,
                                     input logic h);
    return {ir, pw, ps, rw, rs, dw, as, ac, h, st};
  endfunction

  task automatic cyc(input string nm, input logic r, input logic [6:0] op,
                     input logic [2:0] f3, input logic [3:0] fl, input logic [14:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; opcode = op; funct3 = f3; alu_flags = fl;
    x.nm = nm; x.v = e;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      logic [14:0] got;
      x = exp_q.pop_front();
      got = {ir_we, pc_we, pc_src, rf_we, rf_src, d_mem_we, alu_src, alu_cmd, halted, state_dbg};
      n_checks++;
      if (got !== x.v) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b", x.nm, got, x.v);
      end
    end
  end

  initial begin
    cyc("reset0", 1'b1, R_OP, 3'd0, 4'd0, mk(0,0,0,0,0,0,0,0,4'd0,0));
    cyc("reset1", 1'b1, R_OP, 3'd0, 4'd0, mk(0,0,0,0,0,0,0,0,4'd0,0));
    // R-type; opcode scrambled after DECODE must be ignored
    cyc("r_fetch",  1'b0, R_OP,  3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("r_decode", 1'b0, R_OP,  3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("r_exec",   1'b0, 7'h7F, 3'd5, 4'd1, mk(2,0,0,0,0,0,0,0,4'd0,0));
    cyc("r_wb",     1'b0, BAD,   3'd0, 4'd0, mk(4,0,1,0,1,0,0,0,4'd0,0));
    // OP-IMM
    cyc("i_fetch",  1'b0, I_OP, 3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("i_decode", 1'b0, I_OP, 3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("i_exec",   1'b0, I_OP, 3'd0, 4'd0, mk(2,0,0,0,0,0,0,1,4'd1,0));
    cyc("i_wb",     1'b0, I_OP, 3'd0, 4'd0, mk(4,0,1,0,1,0,0,1,4'd1,0));
    // LOAD
    cyc("ld_fetch",  1'b0, LD, 3'd2, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("ld_decode", 1'b0, LD, 3'd2, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("ld_exec",   1'b0, LD, 3'd2, 4'd0, mk(2,0,0,0,0,0,0,1,4'd1,0));
    cyc("ld_mem",    1'b0, LD, 3'd2, 4'd0, mk(3,0,0,0,0,1,0,1,4'd1,0));
    cyc("ld_wb",     1'b0, LD, 3'd2, 4'd0, mk(4,0,1,0,1,1,0,1,4'd1,0));
    // STORE
    cyc("st_fetch",  1'b0, SD, 3'd2, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("st_decode", 1'b0, SD, 3'd2, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("st_exec",   1'b0, SD, 3'd2, 4'd0, mk(2,0,0,0,0,0,0,1,4'd2,0));
    cyc("st_mem",    1'b0, SD, 3'd2, 4'd0, mk(3,0,1,0,0,0,1,1,4'd2,0));
    // BEQ taken / not taken
    cyc("beq_t_fetch",  1'b0, BR, 3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("beq_t_decode", 1'b0, BR, 3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("beq_t_exec",   1'b0, BR, 3'd0, 4'd1, mk(2,0,1,1,0,0,0,0,4'd3,0));
    cyc("beq_n_fetch",  1'b0, BR, 3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("beq_n_decode", 1'b0, BR, 3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("beq_n_exec",   1'b0, BR, 3'd0, 4'd0, mk(2,0,1,0,0,0,0,0,4'd3,0));
    // BNE taken / not taken; funct3 latched in DECODE, later funct3 ignored
    cyc("bne_t_fetch",  1'b0, BR, 3'd1, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("bne_t_decode", 1'b0, BR, 3'd1, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("bne_t_exec",   1'b0, BR, 3'd0, 4'd0, mk(2,0,1,1,0,0,0,0,4'd3,0));
    cyc("bne_n_fetch",  1'b0, BR, 3'd1, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("bne_n_decode", 1'b0, BR, 3'd1, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("bne_n_exec",   1'b0, BR, 3'd1, 4'd1, mk(2,0,1,0,0,0,0,0,4'd3,0));
    // BLT (funct3=100) never taken
    cyc("blt_fetch",  1'b0, BR, 3'd4, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("blt_decode", 1'b0, BR, 3'd4, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("blt_exec",   1'b0, BR, 3'd4, 4'd1, mk(2,0,1,0,0,0,0,0,4'd3,0));
    // R-type with reset during WB
    cyc("rr_fetch",  1'b0, R_OP, 3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("rr_decode", 1'b0, R_OP, 3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    cyc("rr_exec",   1'b0, R_OP, 3'd0, 4'd0, mk(2,0,0,0,0,0,0,0,4'd0,0));
    cyc("rr_wb_rst", 1'b1, R_OP, 3'd0, 4'd0, mk(0,0,0,0,0,0,0,0,4'd0,0));
    cyc("rr_restart",1'b0, R_OP, 3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    // Illegal opcode parks in HALT
    cyc("bad_decode", 1'b0, BAD, 3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    for (int i = 0; i < 10; i++)
      cyc($sformatf("halt_%0d", i), 1'b0, (i % 2 == 0) ? R_OP : LD, 3'd0, 4'd1,
          mk(7,0,0,0,0,0,0,0,4'd0,1));
    cyc("halt_rst",    1'b1, R_OP, 3'd0, 4'd0, mk(0,0,0,0,0,0,0,0,4'd0,0));
    cyc("halt_refetch",1'b0, R_OP, 3'd0, 4'd0, mk(0,1,0,0,0,0,0,0,4'd0,0));
    cyc("halt_redec",  1'b0, R_OP, 3'd0, 4'd0, mk(1,0,0,0,0,0,0,0,4'd0,0));
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
